// File: rtl/store_agu_issue_arb.sv
// store_agu_issue_arb: arbitrates NUM_REQ store-issue requesters onto the single
// store AGU issue port. The winning uop is held in a one-entry output stage.
// The arbiter is round-robin, with a per-requester starvation override. It
// honours AGU stall backpressure and squashes uops younger than a mispredicted
// branch.
// Optional build macro STORE_AGU_ARB_STATS_EN adds two kinds of saturating
// counters: per-requester grant counters and a stalled-cycle counter.
module store_agu_issue_arb #(
    parameter int NUM_REQ      = 2,
    parameter int UOP_W        = 199,
    parameter int ROB_W        = 7,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       IN_branch_valid,
    input  logic [ROB_W-1:0]           IN_branch_robID,
    input  logic [NUM_REQ-1:0]         IN_req_valid,
    input  logic [NUM_REQ*ROB_W-1:0]   IN_req_robID,
    input  logic [NUM_REQ*UOP_W-1:0]   IN_req_uop,
    output logic [NUM_REQ-1:0]         OUT_req_ready,
    input  logic                       IN_stall,
`ifdef STORE_AGU_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]      OUT_statGrants,
    output logic [15:0]                OUT_statStallCyc,
`endif
    output logic                       OUT_valid,
    output logic [UOP_W-1:0]           OUT_uop,
    output logic [ROB_W-1:0]           OUT_robID,
    output logic [1:0]                 OUT_grantIdx
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    // A uop is younger than the branch when (x - branch) is strictly positive
    // in ROB_W-bit modulo arithmetic. An equal robID is the branch itself, so it is not younger.
    function automatic logic younger(input logic bv, input logic [ROB_W-1:0] br,
                                     input logic [ROB_W-1:0] x);
        logic [ROB_W-1:0] diff;
        diff = x - br;
        return bv && !diff[ROB_W-1] && (diff != '0);
    endfunction

    logic [1:0]         rr_ptr;
    logic [7:0]         starve_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic               acc;
    logic               starve_hit;
    logic [1:0]         starve_idx;
    logic [1:0]         rr_idx;
    logic               win_valid;
    logic [1:0]         win_idx;
    logic [NUM_REQ-1:0] grant;
    int                 probe;

    // Eligibility, starvation override and circular round-robin search.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        acc        = !OUT_valid || !IN_stall;
        elig       = '0;
        starve_hit = 1'b0;
        starve_idx = 2'd0;
        rr_idx     = 2'd0;
        probe      = 0;
        grant      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = IN_req_valid[i] &&
                      !younger(IN_branch_valid, IN_branch_robID, IN_req_robID[i*ROB_W +: ROB_W]);
        end
        // Scanning downward leaves the lowest-index starved requester as the winner.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i] && starve_cnt[i] == LIMIT) begin
                starve_hit = 1'b1;
                starve_idx = 2'(i);
            end
        end
        // Scanning offsets downward leaves the first eligible requester at or after rr_ptr.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            probe = int'(rr_ptr) + k;
            if (probe >= NUM_REQ) probe = probe - NUM_REQ;
            if (elig[probe]) rr_idx = 2'(probe);
        end
        win_valid = acc && (|elig);
        win_idx   = starve_hit ? starve_idx : rr_idx;
        if (win_valid) grant[win_idx] = 1'b1;
    end

    // While reset is asserted no requester may dequeue.
    assign OUT_req_ready = rst ? grant : '0;

    // Output stage and round-robin pointer: grant > squash > drain > hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_valid    <= 1'b0;
            OUT_uop      <= '0;
            OUT_robID    <= '0;
            OUT_grantIdx <= 2'd0;
            rr_ptr       <= 2'd0;
        end else if (win_valid) begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
            OUT_valid    <= 1'b1;
            OUT_uop      <= IN_req_uop[int'(win_idx)*UOP_W +: UOP_W];
            OUT_robID    <= IN_req_robID[int'(win_idx)*ROB_W +: ROB_W];
            OUT_grantIdx <= win_idx;
            rr_ptr       <= (int'(win_idx) == NUM_REQ - 1) ? 2'd0 : win_idx + 2'd1;
        end else if (OUT_valid && younger(IN_branch_valid, IN_branch_robID, OUT_robID)) begin
            OUT_valid <= 1'b0;
        end else if (!IN_stall) begin
            OUT_valid <= 1'b0;
        end
    end

    // Starve counters: a requester counts cycles lost while valid, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this small counter array is reset on purpose, because the override reads it on the first cycle.
            for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!IN_req_valid[i] || grant[i]) starve_cnt[i] <= 8'd0;
                else if (starve_cnt[i] != LIMIT)  starve_cnt[i] <= starve_cnt[i] + 8'd1;
            end
        end
    end

`ifdef STORE_AGU_ARB_STATS_EN
    logic [15:0] stat_grants [NUM_REQ];
    logic [15:0] stat_stall;

    // Saturating statistics: grants per requester and cycles the AGU held a uop stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) stat_grants[i] <= 16'd0;
            stat_stall <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && stat_grants[i] != 16'hFFFF) stat_grants[i] <= stat_grants[i] + 16'd1;
            end
            if (OUT_valid && IN_stall && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign OUT_statGrants[g*16 +: 16] = stat_grants[g];
    end
    assign OUT_statStallCyc = stat_stall;
`endif

endmodule
